// File: rtl/mips_pkg.sv
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    FS_START = 2'b00,
    FS_REQ   = 2'b01,
    FS_HOLD  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  input  logic [31:0] rs_fwd,
  input  logic [1:0]  npc_op,
  output logic [31:0] target
);

  logic [31:0] pc_d_plus4;
  logic [31:0] br_off;

  always_comb begin
    pc_d_plus4 = pc_d + 32'd4;
    br_off     = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    case (npc_op)
      NPC_BR:  target = pc_d_plus4 + br_off;
      NPC_J:   target = (pc_d_plus4 & 32'hF000_0000) | ((instr_d << 2) & 32'h0FFF_FFFC);
      NPC_JR:  target = rs_fwd & 32'hFFFF_FFFC;
      default: target = pc_d_plus4;
    endcase
  end

endmodule

// File: rtl/if_fetch_npc.sv
module if_fetch_npc
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic [1:0]  npc_op,
  input  logic        cmp_q,
  input  logic [31:0] rs_fwd,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic [31:0] pc_f
);

  fetch_state_e state_q, state_d;

  logic [31:0] fbuf_instr;
  logic [31:0] fbuf_pc;
  logic        fbuf_v;
  logic [31:0] redir_tgt;
  logic        redir_v;
  logic [31:0] target;
  logic        resolve;

  npc_calc u_npc_calc (
    .pc_d    (pc_d),
    .instr_d (instr_d),
    .rs_fwd  (rs_fwd),
    .npc_op  (npc_op),
    .target  (target)
  );

  assign resolve = valid_d && !stall_d &&
                   ((npc_op == NPC_J) || (npc_op == NPC_JR) || ((npc_op == NPC_BR) && cmp_q));

  assign imem_addr = pc_f;
  assign pc8_d     = pc_d + 32'd8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FS_START;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_START: state_d = FS_REQ;
      FS_REQ:   if (imem_ack && (stall_d || fbuf_v)) state_d = FS_HOLD;
      FS_HOLD:  if (!stall_d) state_d = FS_REQ;
      default:  state_d = FS_START;
    endcase
  end

  always_comb begin
    imem_req = (state_q == FS_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f       <= RESET_PC;
      instr_d    <= '0;
      pc_d       <= '0;
      valid_d    <= 1'b0;
      fbuf_instr <= '0;
      fbuf_pc    <= '0;
      fbuf_v     <= 1'b0;
      redir_tgt  <= '0;
      redir_v    <= 1'b0;
    end else begin
      case (state_q)
        FS_REQ: begin
          if (imem_ack) begin
            if (!stall_d && !fbuf_v) begin
              instr_d <= imem_rdata;
              pc_d    <= pc_f;
              valid_d <= 1'b1;
            end else begin
              fbuf_instr <= imem_rdata;
              fbuf_pc    <= pc_f;
              fbuf_v     <= 1'b1;
            end
            pc_f    <= resolve ? target : (redir_v ? redir_tgt : pc_f + 32'd4);
            redir_v <= 1'b0;
          end else begin
            // D advanced with nothing behind it: leave a NOP bubble so the
            // departed instruction cannot resolve a second time.
            if (!stall_d) begin
              instr_d <= '0;
              valid_d <= 1'b0;
            end
            if (resolve) begin
              redir_v   <= 1'b1;
              redir_tgt <= target;
            end
          end
        end
        FS_HOLD: begin
          if (!stall_d) begin
            instr_d <= fbuf_instr;
            pc_d    <= fbuf_pc;
            valid_d <= 1'b1;
            fbuf_v  <= 1'b0;
            if (resolve) pc_f <= target;
          end
        end
        default: begin
          if (!stall_d) begin
            instr_d <= '0;
            valid_d <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_npc.sv
module tb_if_fetch_npc;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_d = 1'b0;
  logic [1:0]  npc_op = '0;
  logic        cmp_q = 1'b0;
  logic [31:0] rs_fwd = '0;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;
  logic [31:0] pc_f;

  if_fetch_npc #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall_d    (stall_d),
    .npc_op     (npc_op),
    .cmp_q      (cmp_q),
    .rs_fwd     (rs_fwd),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc8_d      (pc8_d),
    .valid_d    (valid_d),
    .pc_f       (pc_f)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
    logic [31:0] rs;
    logic [1:0]  op;
    logic        taken;
  } ent_t;

  int n_chk = 0;
  int n_fail = 0;

  ent_t        exp_q[$];
  logic [31:0] fetch_q[$];
  logic [31:0] prog[logic [31:0]];
  logic [31:0] rs_prog[logic [31:0]];
  logic [31:0] seed;
  bit          stall_q[$];
  int          max_lat = 0;
  int          fixed_lat = 0;
  int          stall_pct = 0;
  bit          mon_en = 0;
  int          popped = 0;

  bit          waiting = 0;
  int          lat = 0;
  logic [31:0] wait_addr = '0;
  bit          e_stall = 0;
  bit          e_xfer = 0;

  ent_t        d_ent;
  bit          d_have = 0;
  bit          buf_m = 0;
  logic [31:0] snap_i, snap_p, snap_8;
  logic        snap_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic note_fail(input string name, input int act, input int req);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ seed;
  endfunction

  function automatic logic [31:0] rs_of(input logic [31:0] pc, input logic [31:0] w);
    if (rs_prog.exists(pc)) return rs_prog[pc];
    return (w * 32'h85EB_CA6B) ^ 32'hC2B2_AE35;
  endfunction

  // Architectural instruction stream: word[31:30] is the class, word[29] the
  // branch outcome; a transfer in a delay slot is decoded as a plain op.
  task automatic build_stream(input int n);
    logic [31:0] pc = RST_PC;
    logic [31:0] tgt = '0;
    bit          pend = 0;
    int          off;
    ent_t        e;
    exp_q.delete();
    fetch_q.delete();
    for (int i = 0; i < n; i++) begin
      e.pc    = pc;
      e.w     = mem_word(pc);
      e.rs    = rs_of(pc, e.w);
      e.op    = e.w[31:30];
      e.taken = (e.op == 2'b01) ? e.w[29] : (e.op != 2'b00);
      fetch_q.push_back(pc);
      if (pend) begin
        e.op    = 2'b00;
        e.taken = 1'b0;
        pc      = tgt;
        pend    = 0;
      end else begin
        if (e.taken) begin
          pend = 1;
          case (e.op)
            2'b01: begin
              off = int'($signed(e.w[15:0]));
              tgt = pc + 32'd4 + 32'(off * 4);
            end
            2'b10:   tgt = ((pc + 32'd4) & 32'hF000_0000) + (32'(e.w[25:0]) * 32'd4);
            default: tgt = e.rs & 32'hFFFF_FFFC;
          endcase
        end
        pc = pc + 32'd4;
      end
      exp_q.push_back(e);
    end
  endtask

  // Memory responder and D-stage decoder.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      imem_ack = 1'b0;
      waiting  = 0;
      e_xfer   = 0;
      e_stall  = 0;
      stall_d  = 1'b0;
    end else begin
      stall_d  = (stall_q.size() > 0) ? stall_q.pop_front() : ($urandom_range(99) < stall_pct);
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      if (imem_req) begin
        if (!waiting) begin
          waiting   = 1;
          wait_addr = imem_addr;
          lat       = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(max_lat));
          chk("addr_align", imem_addr & 32'h3, 32'h0);
          if (fetch_q.size() > 0) chk("fetch_addr", imem_addr, fetch_q.pop_front());
        end else begin
          chk("addr_stable", imem_addr, wait_addr);
        end
        if (lat == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          waiting    = 0;
        end else begin
          lat--;
        end
      end
      e_xfer  = imem_ack;
      e_stall = stall_d;
      if (d_have && !stall_d) begin
        npc_op = d_ent.op;
        cmp_q  = (d_ent.op == 2'b01) ? d_ent.taken : 1'($urandom);
        rs_fwd = d_ent.rs;
      end else begin
        npc_op = 2'($urandom);
        cmp_q  = 1'($urandom);
        rs_fwd = $urandom;
      end
    end
  end

  // Monitor: pops the expected stream whenever IF/ID takes a new instruction.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        if (e_stall) begin
          chk("hold_instr", instr_d, snap_i);
          chk("hold_pc", pc_d, snap_p);
          chk("hold_pc8", pc8_d, snap_8);
          chk("hold_valid", 32'(valid_d), 32'(snap_v));
          if (e_xfer) buf_m = 1;
          if (buf_m) chk("buffered_req", 32'(imem_req), 32'h0);
        end else begin
          chk("valid_d", 32'(valid_d), 32'(e_xfer | buf_m));
          buf_m = 0;
          if (valid_d) begin
            if (exp_q.size() == 0) begin
              note_fail("extra_instr", 1, 0);
              d_have = 0;
            end else begin
              e = exp_q.pop_front();
              chk("pc_d", pc_d, e.pc);
              chk("instr_d", instr_d, e.w);
              chk("pc8_d", pc8_d, e.pc + 32'd8);
              d_ent  = e;
              d_have = 1;
              popped++;
            end
          end else begin
            d_have = 0;
          end
        end
        snap_i = instr_d;
        snap_p = pc_d;
        snap_8 = pc8_d;
        snap_v = valid_d;
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'h0);
    chk({tag, "_pc_f"}, pc_f, RST_PC);
    chk({tag, "_valid"}, 32'(valid_d), 32'h0);
    chk({tag, "_instr"}, instr_d, 32'h0);
    chk({tag, "_pc_d"}, pc_d, 32'h0);
  endtask

  task automatic run_phase(input int n, input int mlat, input int flat, input int spct,
                           input bit abort_mid);
    int cyc = 0;
    bit aborted = 0;
    rst_n  = 1'b0;
    mon_en = 0;
    #1;
    chk_reset("reset");
    build_stream(n + 16);
    max_lat   = mlat;
    fixed_lat = flat;
    stall_pct = spct;
    buf_m  = 0;
    d_have = 0;
    popped = 0;
    snap_i = '0;
    snap_p = '0;
    snap_8 = 32'h8;
    snap_v = 1'b0;
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1;
    #1;
    chk("start_req", 32'(imem_req), 32'h0);
    @(posedge clk);
    #1;
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, RST_PC);
    while (popped < n && cyc < 40 * n + 200 && !aborted) begin
      @(negedge clk);
      cyc++;
      if (abort_mid && popped >= n / 2 && waiting && lat >= 2) aborted = 1;
    end
    if (abort_mid) begin
      if (aborted) begin
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
      end else begin
        note_fail("abort_point", 0, 1);
      end
    end else if (popped < n) begin
      note_fail("timeout_delivered", popped, n);
    end
    stall_q.delete();
  endtask

  initial begin
    seed = $urandom;

    prog.delete(); rs_prog.delete();
    for (int unsigned i = 0; i < 4; i++) prog[RST_PC + 4 * i] = 32'h0011_0000 + i;
    run_phase(4, 0, 0, 0, 0);

    prog.delete(); rs_prog.delete();
    prog[32'h3000] = 32'h6000_0003;
    prog[32'h3004] = 32'h0000_1234;
    run_phase(4, 0, 0, 0, 0);

    prog.delete(); rs_prog.delete();
    prog[32'h3000] = 32'h4000_0003;
    prog[32'h3004] = 32'h0000_1234;
    run_phase(4, 0, 0, 0, 0);

    prog.delete(); rs_prog.delete();
    prog[32'h3000] = 32'hC000_0000;
    prog[32'h3004] = 32'h0000_5678;
    rs_prog[32'h3000] = 32'h0000_4001;
    run_phase(4, 0, 0, 0, 0);

    prog.delete(); rs_prog.delete();
    prog[32'h3000] = 32'h8000_0400;
    prog[32'h3004] = 32'h0000_9abc;
    run_phase(4, 0, 0, 0, 0);

    prog.delete(); rs_prog.delete();
    prog[32'h3000] = 32'h6000_0003;
    prog[32'h3004] = 32'h0000_1234;
    stall_q.push_back(0);
    stall_q.push_back(1);
    stall_q.push_back(1);
    stall_q.push_back(1);
    run_phase(4, 0, 0, 0, 0);

    prog.delete(); rs_prog.delete();
    prog[32'h3000] = 32'h6000_0003;
    prog[32'h3004] = 32'h0000_1234;
    run_phase(4, 0, 4, 0, 0);

    prog.delete(); rs_prog.delete();
    run_phase(20, 0, 4, 0, 1);
    run_phase(6, 0, 0, 0, 0);

    for (int unsigned k = 0; k < 3; k++) begin
      prog.delete(); rs_prog.delete();
      seed = $urandom;
      run_phase(250, 3, -1, 30, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
